wb_stage: RTL and testbench

Write-back stage of the 16-bit pipelined core: holds the MEM/WB pipeline register, selects the result to be written, forms the merged value for LLB/LHB load-half instructions, and drives the register file write port, including the signal that suppresses register-file write-to-read bypass for load-half writes. It also detects a retiring HLT, raises the core-halted status, and freezes. It sits directly upstream of the register file write port.

---
 rtl/wb_stage.sv | 165 ++++++++++++++++
 tb/tb_wb_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage -- write-back stage of the 16-bit pipelined core.
//
// Holds the MEM/WB pipeline register and selects the write-back result.
// LLB and LHB results are merged with the prior destination value.
// Drives the register-file write port. Detects a retiring HLT and then
// freezes in HALTED until the next reset.
//
// Ports:
//   clk, rst            core clock; synchronous active-low reset
//   stall, flush        hold / bubble control for MEM/WB (flush wins)
//   mem_*               MEM-stage instruction fields captured into MEM/WB
//   rf_write_en/reg/data, rf_load_half   register-file write port
//   fwd_valid           WB result available for forwarding (= rf_write_en)
//   halted              high once HLT has retired (FSM state HALTED)
//   retired_count       retired-instruction counter (WB_RETIRE_COUNT_EN only)
//
// Configuration macro: WB_RETIRE_COUNT_EN adds the retired_count port and
// its counter. Without the macro, the port and the counter are absent.
//
// All outputs are driven from registered state only.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic        mem_reg_write,
    input  logic        mem_is_load,
    input  logic        mem_is_llb,
    input  logic        mem_is_lhb,
    input  logic        mem_is_hlt,
    input  logic [3:0]  mem_dst,
    input  logic [15:0] mem_alu_result,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] mem_old_rd,
    input  logic [7:0]  mem_imm8,
    output logic        rf_write_en,
    output logic [3:0]  rf_write_reg,
    output logic [15:0] rf_write_data,
    output logic        rf_load_half,
    output logic        fwd_valid,
    output logic        halted
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [31:0] retired_count
`endif
);

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

    state_e      state_q, state_d;

    logic        valid_q;
    logic        reg_write_q;
    logic        is_load_q;
    logic        is_llb_q;
    logic        is_lhb_q;
    logic        is_hlt_q;
    logic [3:0]  dst_q;
    logic [15:0] alu_result_q;
    logic [15:0] rdata_q;
    logic [15:0] old_rd_q;
    logic [7:0]  imm8_q;

    logic [15:0] result;

    // MEM/WB capture. Once halted, the register is frozen.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            is_load_q    <= 1'b0;
            is_llb_q     <= 1'b0;
            is_lhb_q     <= 1'b0;
            is_hlt_q     <= 1'b0;
            dst_q        <= 4'h0;
            alu_result_q <= 16'h0000;
            rdata_q      <= 16'h0000;
            old_rd_q     <= 16'h0000;
            imm8_q       <= 8'h00;
        end else if (state_q == RUN) begin
            if (flush) begin
                // Only valid matters for a bubble; other fields keep old values.
                valid_q <= 1'b0;
            end else if (!stall) begin
                valid_q      <= mem_valid;
                reg_write_q  <= mem_reg_write;
                is_load_q    <= mem_is_load;
                is_llb_q     <= mem_is_llb;
                is_lhb_q     <= mem_is_lhb;
                is_hlt_q     <= mem_is_hlt;
                dst_q        <= mem_dst;
                alu_result_q <= mem_alu_result;
                rdata_q      <= mem_rdata;
                old_rd_q     <= mem_old_rd;
                imm8_q       <= mem_imm8;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. A valid HLT in MEM/WB halts the stage at the next edge.
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && valid_q && is_hlt_q) begin
            state_d = HALTED;
        end
    end

    // Result select. Load-half forms merge imm8 into one byte of the old value.
    always_comb begin
        result = alu_result_q;
        if (is_llb_q) begin
            result = {old_rd_q[15:8], imm8_q};
        end else if (is_lhb_q) begin
            result = {imm8_q, old_rd_q[7:0]};
        end else if (is_load_q) begin
            result = rdata_q;
        end
    end

    // FSM: outputs. Writes to R0 are dropped.
    always_comb begin
        rf_write_en   = valid_q && reg_write_q && (dst_q != 4'h0) && (state_q == RUN);
        rf_write_reg  = dst_q;
        rf_write_data = result;
        // Load-half writes must not be bypassed by the register file.
        rf_load_half  = rf_write_en && (is_llb_q || is_lhb_q);
        fwd_valid     = rf_write_en;
        halted        = (state_q == HALTED);
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retired_q, retired_d;

    // An entry retires at the edge where it leaves MEM/WB. A stalled entry
    // is therefore counted once. A flush also moves it out, because flush
    // wins over stall.
    always_comb begin
        retired_d = retired_q;
        if (state_q == RUN && valid_q && (!stall || flush)) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            retired_q <= 32'd0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed and random stimulus for wb_stage.
// Each step drives the MEM-stage fields and pushes the expected write-port
// value for the following cycle. The expectation is popped and compared
// 1 ns after the next rising edge.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic        mem_reg_write;
    logic        mem_is_load;
    logic        mem_is_llb;
    logic        mem_is_lhb;
    logic        mem_is_hlt;
    logic [3:0]  mem_dst;
    logic [15:0] mem_alu_result;
    logic [15:0] mem_rdata;
    logic [15:0] mem_old_rd;
    logic [7:0]  mem_imm8;
    logic        rf_write_en;
    logic [3:0]  rf_write_reg;
    logic [15:0] rf_write_data;
    logic        rf_load_half;
    logic        fwd_valid;
    logic        halted;
`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retired_count;
`endif

    // Entry layout: {full, en, reg[3:0], data[15:0], load_half, halted}.
    // When full=0, only en, load_half and halted are compared.
    logic [23:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_is_load    (mem_is_load),
        .mem_is_llb     (mem_is_llb),
        .mem_is_lhb     (mem_is_lhb),
        .mem_is_hlt     (mem_is_hlt),
        .mem_dst        (mem_dst),
        .mem_alu_result (mem_alu_result),
        .mem_rdata      (mem_rdata),
        .mem_old_rd     (mem_old_rd),
        .mem_imm8       (mem_imm8),
        .rf_write_en    (rf_write_en),
        .rf_write_reg   (rf_write_reg),
        .rf_write_data  (rf_write_data),
        .rf_load_half   (rf_load_half),
        .fwd_valid      (fwd_valid),
        .halted         (halted)
`ifdef WB_RETIRE_COUNT_EN
        ,
        .retired_count  (retired_count)
`endif
    );

    // kind: 0 ALU, 1 LW, 2 LLB, 3 LHB, 4 HLT
    task automatic drive(input logic v, input logic rw, input int kind,
                         input logic [3:0] dst, input logic [15:0] alu,
                         input logic [15:0] rdata, input logic [15:0] old,
                         input logic [7:0] imm);
        mem_valid      = v;
        mem_reg_write  = rw;
        mem_is_load    = (kind == 1);
        mem_is_llb     = (kind == 2);
        mem_is_lhb     = (kind == 3);
        mem_is_hlt     = (kind == 4);
        mem_dst        = dst;
        mem_alu_result = alu;
        mem_rdata      = rdata;
        mem_old_rd     = old;
        mem_imm8       = imm;
    endtask

    task automatic expect_out(input logic full, input logic en, input logic [3:0] r,
                              input logic [15:0] d, input logic lh, input logic h);
        exp_q.push_back({full, en, r, d, lh, h});
    endtask

    task automatic tick(input string tag);
        logic [23:0] e;
        logic [22:0] o;
        @(posedge clk);
        #1;
        n_checks++;
        assert (exp_q.size() != 0)
        else begin
            n_fail++;
            $error("FAIL %s: observed empty expectation queue, required one entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = {rf_write_en, rf_write_reg, rf_write_data, rf_load_half, halted};
            n_checks++;
            if (e[23]) begin
                assert (o === e[22:0])
                else begin
                    n_fail++;
                    $error("FAIL %s: observed en/reg/data/lh/halt=%h required %h", tag, o, e[22:0]);
                end
            end else begin
                assert ({o[22], o[1], o[0]} === {e[22], e[1], e[0]})
                else begin
                    n_fail++;
                    $error("FAIL %s: observed en/lh/halt=%b required %b", tag,
                           {o[22], o[1], o[0]}, {e[22], e[1], e[0]});
                end
            end
            n_checks++;
            assert (fwd_valid === e[22])
            else begin
                n_fail++;
                $error("FAIL %s_fwd: observed fwd_valid=%b required %b", tag, fwd_valid, e[22]);
            end
        end
    endtask

    initial begin
        int          kind;
        logic [3:0]  dst;
        logic [15:0] alu, rdata, old, res;
        logic [7:0]  imm;

        rst   = 1'b0;
        stall = 1'b0;
        flush = 1'b0;

        // Reset with a valid instruction presented.
        drive(1, 1, 0, 4'd3, 16'h1234, 16'h0, 16'h0, 8'h0);
        expect_out(1, 0, 4'h0, 16'h0000, 0, 0);
        tick("reset");
`ifdef WB_RETIRE_COUNT_EN
        n_checks++;
        assert (retired_count === 32'd0)
        else begin n_fail++; $error("FAIL cnt_reset: observed %h required 0", retired_count); end
`endif
        rst = 1'b1;

        drive(1, 1, 0, 4'd3, 16'h1234, 16'h0, 16'h0, 8'h0);
        expect_out(1, 1, 4'd3, 16'h1234, 0, 0);
        tick("add_r3");

        drive(1, 1, 1, 4'd5, 16'h0040, 16'hBEEF, 16'h0, 8'h0);
        expect_out(1, 1, 4'd5, 16'hBEEF, 0, 0);
        tick("lw_r5");

        drive(1, 1, 2, 4'd2, 16'h0, 16'h0, 16'hABCD, 8'h5A);
        expect_out(1, 1, 4'd2, 16'hAB5A, 1, 0);
        tick("llb_r2");

        drive(1, 1, 3, 4'd2, 16'h0, 16'h0, 16'hABCD, 8'h5A);
        expect_out(1, 1, 4'd2, 16'h5ACD, 1, 0);
        tick("lhb_r2");

        drive(1, 1, 0, 4'd0, 16'h7777, 16'h0, 16'h0, 8'h0);
        expect_out(0, 0, 4'h0, 16'h0000, 0, 0);
        tick("add_r0");
`ifdef WB_RETIRE_COUNT_EN
        // ADD R3, LW, LLB, LHB have left MEM/WB.
        n_checks++;
        assert (retired_count === 32'd4)
        else begin n_fail++; $error("FAIL cnt_four: observed %h required 4", retired_count); end
`endif

        // Stall and flush together: flush wins and inserts a bubble.
        stall = 1'b1;
        flush = 1'b1;
        drive(1, 1, 0, 4'd6, 16'h6666, 16'h0, 16'h0, 8'h0);
        expect_out(0, 0, 4'h0, 16'h0000, 0, 0);
        tick("stall_flush");
        stall = 1'b0;
        flush = 1'b0;

        drive(1, 1, 0, 4'd7, 16'h0ACE, 16'h0, 16'h0, 8'h0);
        expect_out(1, 1, 4'd7, 16'h0ACE, 0, 0);
        tick("add_r7");

        // Stall for three cycles: the R7 write is held.
        stall = 1'b1;
        drive(1, 1, 0, 4'd8, 16'h1111, 16'h0, 16'h0, 8'h0);
        for (int i = 0; i < 3; i++) begin
            expect_out(1, 1, 4'd7, 16'h0ACE, 0, 0);
            tick("stall_hold");
        end
        stall = 1'b0;
        expect_out(1, 1, 4'd8, 16'h1111, 0, 0);
        tick("add_r8");

        // HLT, then an ADD that must never write.
        drive(1, 0, 4, 4'd0, 16'h0, 16'h0, 16'h0, 8'h0);
        expect_out(0, 0, 4'h0, 16'h0000, 0, 0);
        tick("hlt_enter");
        drive(1, 1, 0, 4'd4, 16'h4444, 16'h0, 16'h0, 8'h0);
        expect_out(0, 0, 4'h0, 16'h0000, 0, 1);
        tick("halted_1");
        expect_out(0, 0, 4'h0, 16'h0000, 0, 1);
        tick("halted_2");

        // Reset while halted.
        rst = 1'b0;
        expect_out(1, 0, 4'h0, 16'h0000, 0, 0);
        tick("reset_halted");
        rst = 1'b1;

        drive(1, 1, 0, 4'd9, 16'h4242, 16'h0, 16'h0, 8'h0);
        expect_out(1, 1, 4'd9, 16'h4242, 0, 0);
        tick("resume_r9");

        // Random non-R0 writes of every result kind.
        for (int i = 0; i < 8; i++) begin
            kind  = $urandom_range(0, 3);
            dst   = 4'($urandom_range(1, 15));
            alu   = 16'($urandom_range(0, 65535));
            rdata = 16'($urandom_range(0, 65535));
            old   = 16'($urandom_range(0, 65535));
            imm   = 8'($urandom_range(0, 255));
            case (kind)
                1:       res = rdata;
                2:       res = {old[15:8], imm};
                3:       res = {imm, old[7:0]};
                default: res = alu;
            endcase
            drive(1, 1, kind, dst, alu, rdata, old, imm);
            expect_out(1, 1, dst, res, kind >= 2, 0);
            tick("random");
        end

`ifdef WB_RETIRE_COUNT_EN
        // A valid entry sits in MEM/WB, and no stall is applied.
        @(negedge clk);
        force dut.retired_q = 32'hFFFFFFFF;
        #1;
        release dut.retired_q;
        drive(1, 1, 0, 4'd1, 16'h0001, 16'h0, 16'h0, 8'h0);
        expect_out(1, 1, 4'd1, 16'h0001, 0, 0);
        tick("wrap_step");
        n_checks++;
        assert (retired_count === 32'd0)
        else begin n_fail++; $error("FAIL cnt_wrap: observed %h required 0", retired_count); end
`endif

        n_checks++;
        assert (exp_q.size() == 0)
        else begin n_fail++; $error("FAIL queue_drain: observed %0d left, required 0", exp_q.size()); end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
